// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the BRISC register file.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
package regfile_pkg;
  localparam int REGFILE_DATA_W = 16;
  localparam int REGFILE_ADDR_W = 4;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG_EN = 1'b1;
`else
  localparam bit ZERO_REG_EN = 1'b0;
`endif
  typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_data_t;
  function automatic int num_regs(input int addr_w);
    return 2 ** addr_w;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, hazard outputs and busy population count.
// Honours REGFILE_ZERO_REG_EN through regfile_pkg::ZERO_REG_EN (busy[0] stays 0).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rega_addr_i,
  input  logic [ADDR_W-1:0] regb_addr_i,
  input  logic              write_enable_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  output logic              rega_busy_o,
  output logic              regb_busy_o,
  output logic              issue_ready_o,
  output logic [ADDR_W:0]   busy_count_o
);
  localparam int N = num_regs(ADDR_W);
  logic [N-1:0]  busy_q, busy_d;
  logic [ADDR_W:0] count_q, count_d;
  logic hit_a, hit_b, hit_i, issue_acc, inc, dec;
  always_comb begin
    hit_a = write_enable_i && (write_addr_i == rega_addr_i);
    hit_b = write_enable_i && (write_addr_i == regb_addr_i);
    hit_i = write_enable_i && (write_addr_i == issue_addr_i);
    rega_busy_o = busy_q[rega_addr_i] && !hit_a;
    regb_busy_o = busy_q[regb_addr_i] && !hit_b;
    issue_ready_o = !busy_q[issue_addr_i] || hit_i;
    issue_acc = issue_valid_i && issue_ready_o;
    inc = issue_acc && !busy_q[issue_addr_i] && !(ZERO_REG_EN && (issue_addr_i == '0));
    // a same-cycle re-issue keeps the register owned, so its writeback is not a release
    dec = write_enable_i && busy_q[write_addr_i] && !(issue_acc && (issue_addr_i == write_addr_i));
    busy_d = busy_q;
    if (write_enable_i) busy_d[write_addr_i] = 1'b0;
    if (issue_acc) busy_d[issue_addr_i] = 1'b1;
    if (ZERO_REG_EN) busy_d[0] = 1'b0;
    count_d = count_q + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
  end
  always_ff @(posedge clk) begin
    busy_q  <= rst ? '0 : busy_d;
    count_q <= rst ? '0 : count_d;
  end
  assign busy_count_o = count_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with write-to-read bypass and busy scoreboard.
// With REGFILE_ZERO_REG_EN defined, register 0 reads as zero and ignores writes.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = REGFILE_DATA_W,
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rega_addr,
  input  logic [ADDR_W-1:0] regb_addr,
  output logic [DATA_W-1:0] rega_data,
  output logic [DATA_W-1:0] regb_data,
  output logic              rega_busy,
  output logic              regb_busy,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  output logic [ADDR_W:0]   busy_count
);
  localparam int N = num_regs(ADDR_W);
  logic [DATA_W-1:0] mem_q [N];
  logic wr_ok;
  assign wr_ok = write_enable && !(ZERO_REG_EN && (write_addr == '0));
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[write_addr] <= write_data;
    end
  end
  always_comb begin
    rega_data = (ZERO_REG_EN && (rega_addr == '0)) ? '0 :
                (write_enable && (write_addr == rega_addr)) ? write_data : mem_q[rega_addr];
    regb_data = (ZERO_REG_EN && (regb_addr == '0)) ? '0 :
                (write_enable && (write_addr == regb_addr)) ? write_data : mem_q[regb_addr];
  end
  regfile_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
    .clk            (clk),
    .rst            (rst),
    .rega_addr_i    (rega_addr),
    .regb_addr_i    (regb_addr),
    .write_enable_i (write_enable),
    .write_addr_i   (write_addr),
    .issue_valid_i  (issue_valid),
    .issue_addr_i   (issue_addr),
    .rega_busy_o    (rega_busy),
    .regb_busy_o    (regb_busy),
    .issue_ready_o  (issue_ready),
    .busy_count_o   (busy_count)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb (default build, r0 ordinary).
module tb_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rega_addr, regb_addr, write_addr, issue_addr;
  logic [15:0] rega_data, regb_data, write_data;
  logic        rega_busy, regb_busy, write_enable, issue_valid, issue_ready;
  logic [4:0]  busy_count;
  int total = 0;
  int passed = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .rega_addr(rega_addr), .regb_addr(regb_addr),
    .rega_data(rega_data), .regb_data(regb_data),
    .rega_busy(rega_busy), .regb_busy(regb_busy),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .issue_ready(issue_ready), .busy_count(busy_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    write_enable = 1'b0; issue_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rega_addr = '0; regb_addr = '0; write_addr = '0; issue_addr = '0;
    write_data = '0; idle();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // reset state across every address on both ports
    for (int a = 0; a < 16; a++) begin
      rega_addr = 4'(a); regb_addr = 4'(15 - a); issue_addr = 4'(a);
      #1;
      chk("rst_rega_data", 32'(rega_data), 32'h0);
      chk("rst_regb_data", 32'(regb_data), 32'h0);
      chk("rst_busy", 32'({rega_busy, regb_busy}), 32'h0);
      chk("rst_ready", 32'(issue_ready), 32'h1);
      @(negedge clk);
    end
    chk("rst_count", 32'(busy_count), 32'h0);
    // bypass: write r5 while reading r5
    write_enable = 1'b1; write_addr = 4'd5; write_data = 16'hBEEF; rega_addr = 4'd5; regb_addr = 4'd6;
    #1;
    chk("bypass_a", 32'(rega_data), 32'hBEEF);
    chk("bypass_b_other", 32'(regb_data), 32'h0);
    @(negedge clk); idle(); #1;
    chk("stored_r5", 32'(rega_data), 32'hBEEF);
    // issue r3, re-issue is blocked, then writeback releases it
    @(negedge clk); issue_valid = 1'b1; issue_addr = 4'd3; rega_addr = 4'd3; #1;
    chk("issue_r3_ready", 32'(issue_ready), 32'h1);
    @(negedge clk); #1;
    chk("reissue_r3_ready", 32'(issue_ready), 32'h0);
    chk("r3_busy", 32'(rega_busy), 32'h1);
    chk("count_after_r3", 32'(busy_count), 32'h1);
    @(negedge clk); issue_valid = 1'b0;
    write_enable = 1'b1; write_addr = 4'd3; write_data = 16'h1234; #1;
    chk("wb_r3_busy_bypass", 32'(rega_busy), 32'h0);
    chk("wb_r3_data", 32'(rega_data), 32'h1234);
    chk("wb_r3_count_same", 32'(busy_count), 32'h1);
    @(negedge clk); idle(); #1;
    chk("count_after_wb3", 32'(busy_count), 32'h0);
    chk("r3_free", 32'(rega_busy), 32'h0);
    // r7: issue, then re-issue with writeback in the same cycle
    @(negedge clk); issue_valid = 1'b1; issue_addr = 4'd7;
    @(negedge clk); write_enable = 1'b1; write_addr = 4'd7; write_data = 16'h00AA; #1;
    chk("r7_ready_via_wb", 32'(issue_ready), 32'h1);
    chk("r7_count_before", 32'(busy_count), 32'h1);
    @(negedge clk); idle(); rega_addr = 4'd7; #1;
    chk("r7_data", 32'(rega_data), 32'h00AA);
    chk("r7_still_busy", 32'(rega_busy), 32'h1);
    chk("r7_count_after", 32'(busy_count), 32'h1);
    // writeback r7 and issue r9 together
    @(negedge clk); write_enable = 1'b1; write_addr = 4'd7; write_data = 16'h0055;
    issue_valid = 1'b1; issue_addr = 4'd9;
    @(negedge clk); idle(); rega_addr = 4'd7; regb_addr = 4'd9; #1;
    chk("r7_released", 32'(rega_busy), 32'h0);
    chk("r9_busy", 32'(regb_busy), 32'h1);
    chk("count_swap", 32'(busy_count), 32'h1);
    chk("r7_data2", 32'(rega_data), 32'h0055);
    // writeback to a non-busy register
    @(negedge clk); write_enable = 1'b1; write_addr = 4'd8; write_data = 16'h0808;
    @(negedge clk); idle(); regb_addr = 4'd8; #1;
    chk("r8_data", 32'(regb_data), 32'h0808);
    chk("r8_not_busy", 32'(regb_busy), 32'h0);
    chk("r8_count", 32'(busy_count), 32'h1);
    // r0 is an ordinary register in the default build
    @(negedge clk); write_enable = 1'b1; write_addr = 4'd0; write_data = 16'hFFFF;
    @(negedge clk); idle(); issue_valid = 1'b1; issue_addr = 4'd0; rega_addr = 4'd0; #1;
    chk("r0_data", 32'(rega_data), 32'hFFFF);
    @(negedge clk); idle(); #1;
    chk("r0_busy_count", 32'(busy_count), 32'h2);
    chk("r0_ready_low", 32'(issue_ready), 32'h0);
    // issue r1, r2, r4 back to back, then reset with a competing write
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); issue_valid = 1'b1; issue_addr = (k == 2) ? 4'd4 : 4'(k + 1);
    end
    @(negedge clk); idle(); #1;
    chk("count_five", 32'(busy_count), 32'h5);
    @(negedge clk); rst = 1'b1; write_enable = 1'b1; write_addr = 4'd1; write_data = 16'h7777;
    issue_valid = 1'b1; issue_addr = 4'd6;
    @(negedge clk); rst = 1'b0; idle(); rega_addr = 4'd1; regb_addr = 4'd5; issue_addr = 4'd1; #1;
    chk("post_rst_count", 32'(busy_count), 32'h0);
    chk("post_rst_r1", 32'(rega_data), 32'h0);
    chk("post_rst_r5", 32'(regb_data), 32'h0);
    chk("post_rst_busy", 32'({rega_busy, regb_busy}), 32'h0);
    chk("post_rst_ready", 32'(issue_ready), 32'h1);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised, clocked register file for the BRISC datapath, with two asynchronous read ports and one synchronous write port.
- Write-to-read bypass, so a value written this cycle is visible on the read ports in the same cycle.
- Per-register busy scoreboard: set when an instruction issues to a destination register, cleared on writeback.
- The control unit uses the busy/ready outputs to stall on read-after-write and write-after-write hazards.

Parameters:
- DATA_W, 16, register data width in bits.
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rega_addr  in  ADDR_W  read port A address.
- regb_addr  in  ADDR_W  read port B address.
- rega_data  out  DATA_W  read port A data (combinational).
- regb_data  out  DATA_W  read port B data (combinational).
- rega_busy  out  1  port A register has a pending write.
- regb_busy  out  1  port B register has a pending write.
- write_enable  in  1  writeback strobe (qualifier, not a clock).
- write_addr  in  ADDR_W  writeback destination.
- write_data  in  DATA_W  writeback value.
- issue_valid  in  1  instruction issuing with destination issue_addr.
- issue_addr  in  ADDR_W  destination register of the issuing instruction.
- issue_ready  out  1  issue may be accepted this cycle.
- busy_count  out  ADDR_W+1  number of registers currently marked busy.

Behaviour:
- Interface decided: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - all NUM_REGS registers cleared to 0, all busy bits cleared, busy_count = 0.
  - rst has priority over write and issue in the same cycle.
  - reset mid-operation discards all pending scoreboard entries.
- Write: on posedge clk, if write_enable && !rst, then reg[write_addr] <= write_data.
- Read, combinational:
  - rega_data = (write_enable && write_addr==rega_addr) ? write_data : reg[rega_addr]. Same rule for port B.
  - Both ports may read the same address.
- Scoreboard:
  - wb_hit(a) = write_enable && write_addr==a.
  - rega_busy = busy[rega_addr] && !wb_hit(rega_addr); regb_busy likewise.
  - issue_ready = !busy[issue_addr] || wb_hit(issue_addr).
  - Issue is accepted when issue_valid && issue_ready; it sets busy[issue_addr] at the next edge.
  - Writeback clears busy[write_addr] at the next edge.
  - Accepted issue and writeback to the same address in one cycle: busy stays 1 (new owner wins).
  - Issue and writeback to different addresses in one cycle: both take effect.
  - Writeback to a non-busy register is legal: data is written, busy stays 0.
  - Issue with issue_ready low is ignored; no state change.
- busy_count:
  - Registered; tracks popcount(busy) exactly.
  - Increments on an accepted issue to a non-busy register.
  - Decrements on a writeback to a busy register, unless the same cycle accepts an issue to that address.
  - Issue to A plus writeback to busy B (A≠B): count unchanged.
  - Range 0..NUM_REGS; cannot overflow by construction.
- Latency: read 0 cycles (bypass); write and scoreboard updates visible 1 cycle after the edge.

Optional Feature:
- Macro REGFILE_ZERO_REG_EN.
- When defined, register 0 is hardwired to zero:
  - reads of address 0 return 0, including under bypass.
  - writes to address 0 are discarded.
  - busy[0] is constant 0 and issue_ready is 1 for issue_addr==0.
  - an issue to address 0 does not change busy_count.
- When undefined, register 0 behaves like any other register.

Decomposition:
- Package regfile_pkg holds:
  - default constants REGFILE_DATA_W=16 and REGFILE_ADDR_W=4.
  - function num_regs(addr_w) = 2**addr_w.
  - typedef reg_addr_t (ADDR_W bits) and reg_data_t (DATA_W bits) for the defaults.
- One sub-module, regfile_scoreboard, is natural. It owns the busy bit vector, issue_ready, rega_busy/regb_busy and busy_count.
- The top-level holds the storage array and the bypass muxes.

Test Plan:
- Reset, then read all 16 addresses on both ports → data 0, busy 0, busy_count 0, issue_ready 1.
- Write 0xBEEF to r5 with rega_addr=5 in the same cycle → rega_data=0xBEEF combinationally; next cycle with write_enable=0 → still 0xBEEF.
- Issue r3; next cycle issue r3 again → issue_ready=0, busy_count=1. Write r3=0x1234 → rega_busy(3)=0 that cycle, busy_count=0 next cycle.
- Same-cycle issue r7 and writeback r7=0x00AA, with r7 busy → r7=0x00AA, busy[7]=1, busy_count unchanged at 1.
- Issue r1, r2, r4 back-to-back, then assert rst with write_enable=1 to r1 → all registers 0, busy_count 0, r1 not written.
- With REGFILE_ZERO_REG_EN defined: write r0=0xFFFF and issue r0 → rega_data(0)=0, issue_ready=1, busy_count=0.
